systolic_array: RTL and testbench

Output-stationary 3×3 systolic matrix multiplier computing C = A·B for unsigned 4-bit elements, with 8-bit accumulators per processing element (PE). A is presented as three packed rows and B as three packed columns. The block skews them internally and streams them through a 3×3 PE mesh, then raises a completion flag. It is a standalone datapath block, driven by a host that holds the operands and samples the nine results.

---
 rtl/systolic_pkg.sv | 42 ++++
 rtl/systolic_pe.sv | 62 ++++++
 rtl/systolic_array.sv | 180 ++++++++++++++++++
 tb/tb_systolic_array.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// ============================================================================
// Module   : systolic_pkg
// Purpose  : Shared sizes, element/accumulator types and the operand lane
//            selector for the 3x3 output-stationary systolic multiplier.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package systolic_pkg;

  localparam int N        = 3;
  localparam int ELEM_W   = 4;
  localparam int ACC_W    = 8;
  localparam int CNT_W    = 3;
  localparam int ROW_W    = N * ELEM_W;
  localparam int DONE_CNT = 7;

  typedef logic [ELEM_W-1:0] elem_t;
  typedef logic [ACC_W-1:0]  acc_t;
  typedef logic [CNT_W-1:0]  cnt_t;

  // Element k = cnt - lane of a packed row/column (element 0 in the MSBs),
  // or zero when k falls outside 0..N-1. This is what produces the skew.
  function automatic elem_t pick_elem(input logic [ROW_W-1:0] bus,
                                      input cnt_t             cnt,
                                      input int               lane);
    elem_t e;
    int    k;
    e = '0;
    k = int'(cnt) - lane;
    case (k)
      0:       e = bus[ROW_W-1 -: ELEM_W];
      1:       e = bus[ROW_W-1-ELEM_W -: ELEM_W];
      2:       e = bus[ELEM_W-1:0];
      default: e = '0;
    endcase
    return e;
  endfunction

endpackage

`default_nettype wire

// File: rtl/systolic_pe.sv
// ============================================================================
// Module   : systolic_pe
// Purpose  : One processing element: multiply-accumulate of the incoming
//            a/b pair, with a forwarded right and b forwarded down.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module systolic_pe
  import systolic_pkg::*;
#(
  parameter int ACC_BITS = ACC_W
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                ENABLE,
  input  elem_t               a_in,
  input  elem_t               b_in,
  output elem_t               a_out,
  output elem_t               b_out,
  output logic [ACC_BITS-1:0] acc
);

  elem_t                a_q, a_d;
  elem_t                b_q, b_d;
  logic [ACC_BITS-1:0]  acc_q, acc_d;
  logic [2*ELEM_W-1:0]  prod_w;

  assign prod_w = {{ELEM_W{1'b0}}, a_in} * {{ELEM_W{1'b0}}, b_in};

  // Next state: accumulate (wrapping) and forward operands when enabled.
  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    acc_d = acc_q;
    if (ENABLE) begin
      a_d   = a_in;
      b_d   = b_in;
      acc_d = acc_q + ACC_BITS'(prod_w);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
    end
  end

  assign a_out = a_q;
  assign b_out = b_q;
  assign acc   = acc_q;

endmodule

`default_nettype wire

// File: rtl/systolic_array.sv
// ============================================================================
// Module   : systolic_array
// Purpose  : 3x3 output-stationary systolic multiplier C = A*B for unsigned
//            4-bit elements with 8-bit wrapping accumulators. Holds the cycle
//            counter, operand skew/injection, done flag and the PE mesh.
// Options  : SYSTOLIC_INPUT_CAPTURE_EN - register all operand buses on the
//            first enabled cycle after reset so the host may release them.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module systolic_array
  import systolic_pkg::*;
#(
  parameter int WIDTH     = 12,
  parameter int WIDTH_SUM = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 ENABLE,
  input  logic [WIDTH-1:0]     A_ROW1,
  input  logic [WIDTH-1:0]     A_ROW2,
  input  logic [WIDTH-1:0]     A_ROW3,
  input  logic [WIDTH-1:0]     B_COLOUM1,
  input  logic [WIDTH-1:0]     B_COLOUM2,
  input  logic [WIDTH-1:0]     B_COLOUM3,
  output logic [WIDTH_SUM-1:0] C_OUT_1x1,
  output logic [WIDTH_SUM-1:0] C_OUT_1x2,
  output logic [WIDTH_SUM-1:0] C_OUT_1x3,
  output logic [WIDTH_SUM-1:0] C_OUT_2x1,
  output logic [WIDTH_SUM-1:0] C_OUT_2x2,
  output logic [WIDTH_SUM-1:0] C_OUT_2x3,
  output logic [WIDTH_SUM-1:0] C_OUT_3x1,
  output logic [WIDTH_SUM-1:0] C_OUT_3x2,
  output logic [WIDTH_SUM-1:0] C_OUT_3x3,
  output logic                 MULTI_OVER
);

  cnt_t               cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_bus_w [N];
  logic [WIDTH-1:0]   b_bus_w [N];
  logic [WIDTH-1:0]   a_src_w [N];
  logic [WIDTH-1:0]   b_src_w [N];
  elem_t              a_inj_w [N];
  elem_t              b_inj_w [N];
  elem_t              a_out_w [N][N];
  elem_t              b_out_w [N][N];
  logic [WIDTH_SUM-1:0] acc_w [N][N];

  assign a_bus_w[0] = A_ROW1;
  assign a_bus_w[1] = A_ROW2;
  assign a_bus_w[2] = A_ROW3;
  assign b_bus_w[0] = B_COLOUM1;
  assign b_bus_w[1] = B_COLOUM2;
  assign b_bus_w[2] = B_COLOUM3;

  // Counter next state: count enabled cycles, saturating at the done value.
  always_comb begin
    cnt_d = cnt_q;
    if (ENABLE && (cnt_q != cnt_t'(DONE_CNT))) begin
      cnt_d = cnt_q + cnt_t'(1);
    end
  end

  // Counter register; reset wins over enable.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

`ifdef SYSTOLIC_INPUT_CAPTURE_EN
  logic [WIDTH-1:0] a_cap_q [N];
  logic [WIDTH-1:0] a_cap_d [N];
  logic [WIDTH-1:0] b_cap_q [N];
  logic [WIDTH-1:0] b_cap_d [N];

  // Capture next state: load all buses on the first enabled cycle of a run.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      a_cap_d[i] = a_cap_q[i];
      b_cap_d[i] = b_cap_q[i];
      if (ENABLE && (cnt_q == '0)) begin
        a_cap_d[i] = a_bus_w[i];
        b_cap_d[i] = b_bus_w[i];
      end
    end
  end

  // Capture registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < N; i++) begin
        a_cap_q[i] <= '0;
        b_cap_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        a_cap_q[i] <= a_cap_d[i];
        b_cap_q[i] <= b_cap_d[i];
      end
    end
  end

  // On the capture cycle itself the registers are not loaded yet, so the
  // live bus (the very value being captured) feeds injection.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      a_src_w[i] = (cnt_q == '0) ? a_bus_w[i] : a_cap_q[i];
      b_src_w[i] = (cnt_q == '0) ? b_bus_w[i] : b_cap_q[i];
    end
  end
`else
  // Injection reads the host buses directly.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      a_src_w[i] = a_bus_w[i];
      b_src_w[i] = b_bus_w[i];
    end
  end
`endif

  // Edge injection: lane i is skewed by i cycles.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      a_inj_w[i] = pick_elem(a_src_w[i], cnt_q, i);
      b_inj_w[i] = pick_elem(b_src_w[i], cnt_q, i);
    end
  end

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_row
      for (genvar gj = 0; gj < N; gj++) begin : g_col
        elem_t a_src;
        elem_t b_src;

        if (gj == 0) begin : g_left_edge
          assign a_src = a_inj_w[gi];
        end else begin : g_left_nbr
          assign a_src = a_out_w[gi][gj-1];
        end

        if (gi == 0) begin : g_top_edge
          assign b_src = b_inj_w[gj];
        end else begin : g_top_nbr
          assign b_src = b_out_w[gi-1][gj];
        end

        systolic_pe #(
          .ACC_BITS (WIDTH_SUM)
        ) u_pe (
          .CLK    (CLK),
          .RST    (RST),
          .ENABLE (ENABLE),
          .a_in   (a_src),
          .b_in   (b_src),
          .a_out  (a_out_w[gi][gj]),
          .b_out  (b_out_w[gi][gj]),
          .acc    (acc_w[gi][gj])
        );
      end
    end
  endgenerate

  assign C_OUT_1x1  = acc_w[0][0];
  assign C_OUT_1x2  = acc_w[0][1];
  assign C_OUT_1x3  = acc_w[0][2];
  assign C_OUT_2x1  = acc_w[1][0];
  assign C_OUT_2x2  = acc_w[1][1];
  assign C_OUT_2x3  = acc_w[1][2];
  assign C_OUT_3x1  = acc_w[2][0];
  assign C_OUT_3x2  = acc_w[2][1];
  assign C_OUT_3x3  = acc_w[2][2];
  assign MULTI_OVER = (cnt_q == cnt_t'(DONE_CNT));

endmodule

`default_nettype wire

// File: tb/tb_systolic_array.sv
// ============================================================================
// Module   : tb_systolic_array
// Purpose  : Directed, table-driven bench for the 3x3 systolic multiplier.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_systolic_array;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ENABLE;
  logic [11:0] A_ROW1, A_ROW2, A_ROW3;
  logic [11:0] B_COLOUM1, B_COLOUM2, B_COLOUM3;
  logic [7:0]  C_OUT_1x1, C_OUT_1x2, C_OUT_1x3;
  logic [7:0]  C_OUT_2x1, C_OUT_2x2, C_OUT_2x3;
  logic [7:0]  C_OUT_3x1, C_OUT_3x2, C_OUT_3x3;
  logic        MULTI_OVER;

  always #5 CLK = ~CLK;

  systolic_array #(
    .WIDTH     (12),
    .WIDTH_SUM (8)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .ENABLE     (ENABLE),
    .A_ROW1     (A_ROW1),
    .A_ROW2     (A_ROW2),
    .A_ROW3     (A_ROW3),
    .B_COLOUM1  (B_COLOUM1),
    .B_COLOUM2  (B_COLOUM2),
    .B_COLOUM3  (B_COLOUM3),
    .C_OUT_1x1  (C_OUT_1x1),
    .C_OUT_1x2  (C_OUT_1x2),
    .C_OUT_1x3  (C_OUT_1x3),
    .C_OUT_2x1  (C_OUT_2x1),
    .C_OUT_2x2  (C_OUT_2x2),
    .C_OUT_2x3  (C_OUT_2x3),
    .C_OUT_3x1  (C_OUT_3x1),
    .C_OUT_3x2  (C_OUT_3x2),
    .C_OUT_3x3  (C_OUT_3x3),
    .MULTI_OVER (MULTI_OVER)
  );

  // a = {row1,row2,row3}, b = {col1,col2,col3}, c = {c11,c12,...,c33}
  typedef struct {
    string       name;
    logic [35:0] a;
    logic [35:0] b;
    logic [71:0] c;
  } vec_t;

  vec_t vecs [5];
  int   total = 0;
  int   bad   = 0;

  logic [7:0] cq [9];
  assign cq[0] = C_OUT_1x1;
  assign cq[1] = C_OUT_1x2;
  assign cq[2] = C_OUT_1x3;
  assign cq[3] = C_OUT_2x1;
  assign cq[4] = C_OUT_2x2;
  assign cq[5] = C_OUT_2x3;
  assign cq[6] = C_OUT_3x1;
  assign cq[7] = C_OUT_3x2;
  assign cq[8] = C_OUT_3x3;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [71:0] exp);
    for (int n = 0; n < 9; n++) begin
      chk($sformatf("%s c%0d%0d", tag, n / 3 + 1, n % 3 + 1), {8'h00, cq[n]},
          {8'h00, exp[71 - 8*n -: 8]});
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_ops(input logic [35:0] a, input logic [35:0] b);
    A_ROW1    = a[35:24];
    A_ROW2    = a[23:12];
    A_ROW3    = a[11:0];
    B_COLOUM1 = b[35:24];
    B_COLOUM2 = b[23:12];
    B_COLOUM3 = b[11:0];
  endtask

  task automatic do_reset();
    RST = 1'b1;
    step();
    RST = 1'b0;
  endtask

  localparam logic [35:0] A1 = 36'h123_456_789;
  localparam logic [35:0] B1 = 36'h147_258_369;
  localparam logic [71:0] C1 = {8'd30, 8'd36, 8'd42, 8'd66, 8'd81, 8'd96,
                                8'd102, 8'd126, 8'd150};
  localparam logic [35:0] A2 = 36'h722_409_789;
  localparam logic [35:0] B2 = 36'hA47_258_4B2;
  localparam logic [71:0] C2 = {8'd92, 8'd40, 8'd54, 8'd103, 8'd80, 8'd34,
                                8'd165, 8'd126, 8'd134};
  localparam logic [35:0] ID = 36'h100_010_001;

  initial begin
    vecs[0] = '{name: "abc", a: A1, b: B1, c: C1};
    vecs[1] = '{name: "mixed", a: A2, b: B2, c: C2};
    vecs[2] = '{name: "allF", a: 36'hFFF_FFF_FFF, b: 36'hFFF_FFF_FFF,
                c: {9{8'd163}}};
    vecs[3] = '{name: "idA", a: ID, b: B1,
                c: {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9}};
    vecs[4] = '{name: "idB", a: A2, b: ID,
                c: {8'd7, 8'd2, 8'd2, 8'd4, 8'd0, 8'd9, 8'd7, 8'd8, 8'd9}};

    RST    = 1'b1;
    ENABLE = 1'b1;
    set_ops(A1, B1);
    #1;

    // Reset with ENABLE high: reset must win.
    do_reset();
    chk_all("reset", '0);
    chk("reset done", {15'd0, MULTI_OVER}, 16'd0);

    // Table-driven full runs.
    for (int v = 0; v < 5; v++) begin
      set_ops(vecs[v].a, vecs[v].b);
      ENABLE = 1'b1;
      do_reset();
      for (int e = 1; e <= 6; e++) begin
        step();
        if (e == 3) chk({vecs[v].name, " c11@3"}, {8'h00, cq[0]},
                        {8'h00, vecs[v].c[71:64]});
      end
      chk({vecs[v].name, " done@6"}, {15'd0, MULTI_OVER}, 16'd0);
      step();
      chk_all(vecs[v].name, vecs[v].c);
      chk({vecs[v].name, " done@7"}, {15'd0, MULTI_OVER}, 16'd1);
      step();
      chk_all({vecs[v].name, " hold"}, vecs[v].c);
      chk({vecs[v].name, " done hold"}, {15'd0, MULTI_OVER}, 16'd1);
    end

    // Enable gap of 3 cycles at cnt = 3; partial sums must freeze.
    set_ops(A1, B1);
    ENABLE = 1'b1;
    do_reset();
    repeat (3) step();
    chk_all("gap pre", {8'd30, 8'd12, 8'd3, 8'd24, 8'd8, 8'd0, 8'd7, 8'd0, 8'd0});
    ENABLE = 1'b0;
    for (int g = 0; g < 3; g++) begin
      step();
      chk_all($sformatf("gap%0d", g),
              {8'd30, 8'd12, 8'd3, 8'd24, 8'd8, 8'd0, 8'd7, 8'd0, 8'd0});
      chk($sformatf("gap%0d done", g), {15'd0, MULTI_OVER}, 16'd0);
    end
    ENABLE = 1'b1;
    repeat (3) step();
    chk("gap done@9", {15'd0, MULTI_OVER}, 16'd0);
    step();
    chk("gap done@10", {15'd0, MULTI_OVER}, 16'd1);
    chk_all("gap final", C1);

    // Reset mid-run at cnt = 4, then rerun with new operands.
    set_ops(A1, B1);
    ENABLE = 1'b1;
    do_reset();
    repeat (4) step();
    set_ops(A2, B2);
    RST = 1'b1;
    step();
    chk_all("midrst", '0);
    chk("midrst done", {15'd0, MULTI_OVER}, 16'd0);
    RST = 1'b0;
    repeat (6) step();
    chk("rerun done@6", {15'd0, MULTI_OVER}, 16'd0);
    step();
    chk_all("rerun", C2);
    chk("rerun done@7", {15'd0, MULTI_OVER}, 16'd1);

`ifdef SYSTOLIC_INPUT_CAPTURE_EN
    // Operands released right after the capture edge.
    set_ops(A2, B2);
    ENABLE = 1'b1;
    do_reset();
    step();
    set_ops('0, '0);
    repeat (6) step();
    chk_all("capture", C2);
    chk("capture done", {15'd0, MULTI_OVER}, 16'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
